// File: rtl/dmem_pkg.sv
// Shared state encoding and default sizing for the data-memory responder.
package dmem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 128;
  localparam int DMEM_CNT_W  = 16;

endpackage

// File: rtl/dmem_responder_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, async clear.
// One-cycle update latency; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// SRAM-style data memory for the single-cycle core: zero-sweep after reset, comb reads, clocked writes.
// Zero-latency reads, no backpressure; optional per-word parity under DMEM_PARITY_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int CNT_W      = DMEM_CNT_W,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              ready,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              access_err,
  input  logic              inj_par,
  output logic              par_err
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   init_ptr, ptr_nxt;
  logic                acc_nxt;
  logic                sweep_we;
  logic                rd_acc;
  logic                wr_acc;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      init_ptr   <= '0;
      access_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      init_ptr   <= ptr_nxt;
      access_err <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = init_ptr;
    acc_nxt   = access_err;
    sweep_we  = 1'b0;
    case (state)
      ST_INIT: begin
        if (INIT_CLEAR != 0) begin
          sweep_we = 1'b1;
          ptr_nxt  = init_ptr + 1'b1;
          if (init_ptr == ADDR_W'(DEPTH - 1)) begin
            state_nxt = ST_RUN;
          end
        end else begin
          state_nxt = ST_RUN;
        end
        // Any access before the array is ready is dropped and flagged.
        if (!CEN) begin
          acc_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  assign ready  = (state == ST_RUN);
  assign rd_acc = ready && !CEN && WEN;
  assign wr_acc = ready && !CEN && !WEN;
  assign Q      = (rd_acc && !OEN) ? mem[A] : '0;

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[init_ptr] <= '0;
    end else if (wr_acc) begin
      mem[A] <= D;
    end
  end

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_acc),
    .cnt   (rd_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_acc),
    .cnt   (wr_cnt)
  );

`ifdef DMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_err_q;

  // inj_par flips the stored bit so a later read sees a deliberate mismatch.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      par_mem[init_ptr] <= 1'b0;
    end else if (wr_acc) begin
      par_mem[A] <= (^D) ^ inj_par;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (rd_acc && ((^mem[A]) != par_mem[A])) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q;
`else
  logic unused_inj_par;
  assign unused_inj_par = inj_par;
  assign par_err        = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave for the single-cycle MIPS core's SRAM-style interface.
- Accepts CEN/WEN/OEN/A/D from the core and returns Q, which feeds the core's ReadDataMem.
- After reset it sweeps the array to zero, then serves combinational reads and clocked writes.
- Keeps saturating read/write counters and a sticky access-error flag for testbench visibility.

Parameters:
ADDR_W, 7, word-address width (matches the core's A[6:0])
DATA_W, 32, data width
DEPTH, 128, number of words; must equal 2**ADDR_W
CNT_W, 16, width of the read and write counters
INIT_CLEAR, 1, 1 = zero-sweep after reset; 0 = skip the sweep and go straight to RUN

Ports:
clk  in  1  clock, posedge
rst_n  in  1  asynchronous active-low reset
CEN  in  1  chip enable, active low
WEN  in  1  0 = write, 1 = read (meaningful only when CEN=0)
OEN  in  1  output enable, active low
A  in  ADDR_W  word address
D  in  DATA_W  write data
Q  out  DATA_W  read data to the core
ready  out  1  1 once the sweep has finished
rd_cnt  out  CNT_W  number of accepted reads
wr_cnt  out  CNT_W  number of accepted writes
access_err  out  1  sticky; set by any access attempted while not ready
inj_par  in  1  parity fault injection (used only with DMEM_PARITY_EN)
par_err  out  1  sticky parity error (0 when the feature is compiled out)

Behaviour:
- Reset values (async on rst_n low): state=ST_INIT, init_ptr=0, ready=0, rd_cnt=0, wr_cnt=0, access_err=0, par_err=0.
  - The array is not reset directly; only the sweep clears it.
  - Q is combinational; during reset it reads 0 because ready=0.
- ST_INIT (INIT_CLEAR=1):
  - Each posedge writes 0 to mem[init_ptr] and increments init_ptr.
  - On the edge that writes init_ptr==DEPTH-1, the block moves to ST_RUN and ready becomes 1.
  - Sweep length is exactly DEPTH cycles; ready rises on the DEPTHth posedge after rst_n deasserts.
- INIT_CLEAR=0: the first posedge after reset moves to ST_RUN with ready=1; array contents are left undefined.
- Access while not ready: CEN=0 during ST_INIT
  - sets access_err at the next posedge;
  - writes are dropped, counters are unchanged, Q=0.
- ST_RUN, read: CEN=0, WEN=1, OEN=0 → Q=mem[A], combinational with zero latency, as the single-cycle core requires.
  - With CEN=1 or OEN=1, Q=0.
- ST_RUN, write: CEN=0, WEN=0 → mem[A]<=D at the posedge. Q=0 during that cycle.
- Read-after-write: a read of the same address in the following cycle returns the new data.
- Counters:
  - At each posedge in ST_RUN, rd_cnt increments on an accepted read (CEN=0, WEN=1); wr_cnt increments on an accepted write.
  - Both saturate at all-ones and never wrap.
  - OEN does not affect counting.
- Address: A spans all DEPTH words, so no address can be out of range.
- Reset mid-sweep or mid-run: the state returns immediately to ST_INIT with ptr=0 and the sweep restarts. Writes in flight at the reset edge are lost.
- ST_RUN has no exit other than reset.

Optional Feature:
- DMEM_PARITY_EN defined:
  - Each word stores an extra bit, the even parity of D XOR inj_par, on writes.
  - The sweep stores parity 0.
  - A RUN-state read whose recomputed parity mismatches the stored bit sets par_err at the next posedge; par_err is sticky until reset.
- Not defined:
  - No parity storage.
  - par_err is tied to 0 and inj_par is ignored.
  - Ports are identical in both builds.

Decomposition:
- Package dmem_pkg holds:
  - state encoding ST_INIT / ST_RUN;
  - default constants DMEM_ADDR_W=7, DMEM_DATA_W=32, DMEM_DEPTH=128, DMEM_CNT_W=16.
- One sub-module, sat_counter: parameter W; inputs clk, rst_n, inc; output cnt; saturates at all-ones. It is instantiated twice, once for rd_cnt and once for wr_cnt.

Test Plan:
- Reset → ready: rst_n low 3 cycles then high → ready=0 for 127 posedges and 1 after the 128th; a read of A=5 returns 0x00000000.
- Write then read: write D=0xDEADBEEF to A=0x12, then the next cycle read A=0x12 with OEN=0 → Q=0xDEADBEEF; wr_cnt=1, rd_cnt=1. With OEN=1 → Q=0.
- Access during sweep: at cycle 10 of the sweep, write A=3 D=0x55 → access_err=1, wr_cnt=0. After ready, a read of A=3 returns 0.
- Counter saturation: CNT_W=4, 20 consecutive reads → rd_cnt=0xF and holds.
- Reset mid-run: write A=7 D=1, assert rst_n mid-cycle → ready=0, counters 0, the sweep reruns, and a read of A=7 afterwards returns 0.
- Parity (DMEM_PARITY_EN): write A=9 D=0x1 with inj_par=1, then read A=9 → par_err=1 next cycle and stays set; a clean write and read leave par_err=0.
